full_adder_checker: RTL and testbench

Synthesizable response checker for the clocked 1-bit full adder. It samples the same `{cin, a, b}` stimulus driven into the adder and computes the expected `{cout, sum}`. It delays that expectation by the adder's pipeline latency, then compares it against the adder's actual outputs. It sits beside the adder in self-checking benches and on-chip BIST wrappers, reporting vector count, error count, first-failure capture and a pass/fail verdict.

---
 rtl/full_adder_checker.sv | 128 ++++++++++++
 tb/tb_full_adder_checker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/full_adder_checker.sv
// Response checker for a clocked 1-bit full adder: predicts {cout,sum} from the
// sampled stimulus, delays it by LATENCY cycles and scores the adder's response.
module full_adder_checker #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             sum,
  input  logic             cout,
  output logic             busy,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [2:0]       first_err_vec,
  output logic [1:0]       first_err_got,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             pass,
  output logic             fail
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_q;
  logic [3:0]         drain_q;
  logic [LATENCY-1:0] vld_q;
  logic [2:0]         vec_q [LATENCY];
  logic [1:0]         exp_q [LATENCY];
  logic [CNT_W-1:0]   vec_cnt_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic [2:0]         fe_vec_q;
  logic [1:0]         fe_got_q;
  logic [CNT_W-1:0]   fe_idx_q;

  logic sample_d;
  logic open_d;
  logic cmp_d;
  logic mism_d;

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {1'b0, x} + {1'b0, y} + {1'b0, c};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign sample_d = (state_q == RUN) && !stop;
  assign open_d   = start && ((state_q == IDLE) || (state_q == DONE));
  assign cmp_d    = vld_q[LATENCY-1];
  assign mism_d   = cmp_d && ({cout, sum} != exp_q[LATENCY-1]);

  // Control: FSM, valid pipeline, counters and first-failure capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      drain_q   <= '0;
      vld_q     <= '0;
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
      fe_vec_q  <= '0;
      fe_got_q  <= '0;
      fe_idx_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE:  if (start) state_q <= RUN;
        RUN: begin
          if (stop) begin
            state_q <= DRAIN;
            drain_q <= '0;
          end
        end
        DRAIN: begin
          if (drain_q == 4'(LATENCY - 1)) state_q <= DONE;
          else                            drain_q <= drain_q + 4'd1;
        end
        DONE:  if (start) state_q <= RUN;
        default: state_q <= IDLE;
      endcase

      if (open_d) begin
        vld_q     <= '0;
        vec_cnt_q <= '0;
        err_cnt_q <= '0;
        fe_vec_q  <= '0;
        fe_got_q  <= '0;
        fe_idx_q  <= '0;
      end else begin
        vld_q[0] <= sample_d;
        for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
        if (cmp_d) vec_cnt_q <= sat_inc(vec_cnt_q);
        if (mism_d) begin
          err_cnt_q <= sat_inc(err_cnt_q);
          // Only the very first mismatch of a session is captured
          if (err_cnt_q == '0) begin
            fe_vec_q <= vec_q[LATENCY-1];
            fe_got_q <= {cout, sum};
            fe_idx_q <= vec_cnt_q;
          end
        end
      end
    end
  end

  // Data: stimulus and expectation travel with their valid bit, no reset needed
  always_ff @(posedge clk) begin
    vec_q[0] <= {cin, a, b};
    exp_q[0] <= full_add(a, b, cin);
    for (int i = 1; i < LATENCY; i++) begin
      vec_q[i] <= vec_q[i-1];
      exp_q[i] <= exp_q[i-1];
    end
  end

  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign vec_cnt       = vec_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_vec = fe_vec_q;
  assign first_err_got = fe_got_q;
  assign first_err_idx = fe_idx_q;
  assign pass          = (state_q == DONE) && (err_cnt_q == '0) && (vec_cnt_q != '0);
  assign fail          = (state_q == DONE) && (err_cnt_q != '0);

endmodule

// File: tb/tb_full_adder_checker.sv
// Directed bench: three checkers (latency 1, latency 3, 4-bit counters) share one
// stimulus stream and a latency-1 adder model with injectable faults.
module tb_full_adder_checker;

  logic clk = 1'b0;
  logic rst_n, start, stop, a, b, cin;
  logic rs_q, rc_q, sum_m, cout_m;
  int   mode;
  int   tests = 0;
  int   failed = 0;

  logic        busy1, pass1, fail1;
  logic [15:0] vec1, err1, fidx1;
  logic [2:0]  fvec1;
  logic [1:0]  fgot1;

  logic        busy3, pass3, fail3;
  logic [15:0] vec3, err3, fidx3;
  logic [2:0]  fvec3;
  logic [1:0]  fgot3;

  logic        busy4, pass4, fail4;
  logic [3:0]  vec4, err4, fidx4;
  logic [2:0]  fvec4;
  logic [1:0]  fgot4;

  always #5 clk = ~clk;

  // Adder under test: one register stage; mode 1 = cout stuck-at-0, mode 2 = sum inverted
  always_ff @(posedge clk) {rc_q, rs_q} <= {1'b0, a} + {1'b0, b} + {1'b0, cin};
  assign sum_m  = (mode == 2) ? ~rs_q : rs_q;
  assign cout_m = (mode == 1) ? 1'b0 : rc_q;

  full_adder_checker #(.LATENCY(1), .CNT_W(16)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .a(a), .b(b), .cin(cin),
    .sum(sum_m), .cout(cout_m), .busy(busy1), .vec_cnt(vec1), .err_cnt(err1),
    .first_err_vec(fvec1), .first_err_got(fgot1), .first_err_idx(fidx1),
    .pass(pass1), .fail(fail1));

  full_adder_checker #(.LATENCY(3), .CNT_W(16)) u_l3 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .a(a), .b(b), .cin(cin),
    .sum(sum_m), .cout(cout_m), .busy(busy3), .vec_cnt(vec3), .err_cnt(err3),
    .first_err_vec(fvec3), .first_err_got(fgot3), .first_err_idx(fidx3),
    .pass(pass3), .fail(fail3));

  full_adder_checker #(.LATENCY(1), .CNT_W(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .a(a), .b(b), .cin(cin),
    .sum(sum_m), .cout(cout_m), .busy(busy4), .vec_cnt(vec4), .err_cnt(err4),
    .first_err_vec(fvec4), .first_err_got(fgot4), .first_err_idx(fidx4),
    .pass(pass4), .fail(fail4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [2:0] v);
    {cin, a, b} = v;
    tick(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    {cin, a, b} = 3'b000;
    tick(1);
    stop = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; {cin, a, b} = 3'b000; mode = 0;
    tick(2);
    chk("rst_busy", busy1, 0);
    chk("rst_vec", vec1, 0);
    chk("rst_err", err1, 0);
    chk("rst_fvec", fvec1, 0);
    chk("rst_fgot", fgot1, 0);
    chk("rst_fidx", fidx1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_fail", fail1, 0);
    rst_n = 1'b1;
    tick(1);

    // Correct adder, all eight vectors
    pulse_start();
    chk("t1_busy_run", busy1, 1);
    for (int i = 0; i < 8; i++) send(3'(i));
    pulse_stop();
    chk("t1_busy_drain", busy1, 1);
    chk("t1_pass_drain", pass1, 0);
    tick(1);
    chk("t1_busy_done", busy1, 0);
    chk("t1_vec", vec1, 8);
    chk("t1_err", err1, 0);
    chk("t1_pass", pass1, 1);
    chk("t1_fail", fail1, 0);
    chk("t1_c4_vec", vec4, 8);
    tick(1);
    chk("t1_l3_busy_drain", busy3, 1);
    tick(1);
    chk("t1_l3_busy_done", busy3, 0);

    // cout stuck-at-0
    mode = 1;
    pulse_start();
    for (int i = 0; i < 8; i++) send(3'(i));
    pulse_stop();
    tick(1);
    chk("t2_vec", vec1, 8);
    chk("t2_err", err1, 4);
    chk("t2_fvec", fvec1, 3'b011);
    chk("t2_fgot", fgot1, 2'b00);
    chk("t2_fidx", fidx1, 3);
    chk("t2_fail", fail1, 1);
    chk("t2_pass", pass1, 0);
    tick(2);

    // Alternating 000/111: latency-3 checker misaligned, latency-1 clean
    mode = 0;
    pulse_start();
    for (int i = 0; i < 8; i++) send((i % 2) ? 3'b111 : 3'b000);
    pulse_stop();
    tick(1);
    chk("t3_l1_vec", vec1, 8);
    chk("t3_l1_err", err1, 0);
    chk("t3_l1_pass", pass1, 1);
    tick(2);
    chk("t3_l3_vec", vec3, 8);
    chk("t3_l3_err_nonzero", (err3 != 0), 1);
    chk("t3_l3_fail", fail3, 1);

    // Saturation with 4-bit counters, sum inverted
    mode = 2;
    pulse_start();
    for (int i = 0; i < 20; i++) send(3'(i % 8));
    pulse_stop();
    tick(1);
    chk("t4_c4_vec", vec4, 15);
    chk("t4_c4_err", err4, 15);
    chk("t4_c4_fidx", fidx4, 0);
    chk("t4_c4_fgot", fgot4, 2'b01);
    chk("t4_c4_fail", fail4, 1);
    chk("t4_l1_vec", vec1, 20);
    chk("t4_l1_err", err1, 20);
    tick(2);

    // Reset mid-RUN aborts the session
    pulse_start();
    for (int i = 0; i < 5; i++) send(3'(i + 1));
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("t5_busy", busy1, 0);
    chk("t5_vec", vec1, 0);
    chk("t5_err", err1, 0);
    chk("t5_fvec", fvec1, 0);
    chk("t5_fgot", fgot1, 0);
    chk("t5_fidx", fidx1, 0);
    chk("t5_pass", pass1, 0);
    chk("t5_fail", fail1, 0);
    tick(1);
    chk("t5_vec_idle", vec1, 0);
    mode = 0;
    pulse_start();
    send(3'b101);
    send(3'b110);
    pulse_stop();
    tick(1);
    chk("t5_vec2", vec1, 2);
    chk("t5_pass2", pass1, 1);
    tick(2);

    // start+stop together, start during DRAIN ignored, start in DONE clears
    pulse_start();
    send(3'b001);
    send(3'b010);
    send(3'b100);
    {cin, a, b} = 3'b111;
    start = 1'b1; stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("t6_busy_drain", busy1, 1);
    chk("t6_vec_drain", vec1, 3);
    tick(1);
    start = 1'b0;
    chk("t6_busy_done", busy1, 0);
    chk("t6_vec", vec1, 3);
    chk("t6_pass", pass1, 1);
    tick(1);
    chk("t6_l3_busy", busy3, 1);
    tick(1);
    chk("t6_l3_busy_done", busy3, 0);
    chk("t6_l3_vec", vec3, 3);
    pulse_start();
    chk("t6_restart_busy", busy1, 1);
    chk("t6_restart_vec", vec1, 0);
    chk("t6_restart_err", err1, 0);
    chk("t6_restart_pass", pass1, 0);
    pulse_stop();
    tick(1);
    chk("t6_zero_busy", busy1, 0);
    chk("t6_zero_pass", pass1, 0);
    chk("t6_zero_fail", fail1, 0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
